// File: rtl/mem_stage_lsu_if.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu_if : data-memory request/response bus between LSU and memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_stage_lsu_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_resp_valid;
  logic        dmem_resp_err;
  logic [31:0] dmem_resp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_err, dmem_resp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_err, dmem_resp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu : memory-stage load/store unit (one bus transaction per access)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic        valid_in,
  input  wire logic        mem_read_in,
  input  wire logic        mem_write_in,
  input  wire logic [2:0]  funct3_in,
  input  wire logic [31:0] addr_in,
  input  wire logic [31:0] wdata_in,
  input  wire logic        flush_in,
  mem_stage_lsu_if.master  dmem,
  output logic [31:0]      load_data_out,
  output logic             done_out,
  output logic             stall_out,
  output logic             misalign_out,
  output logic             bus_err_out,
  output logic [31:0]      fault_addr_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic             req_valid_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [2:0]       funct3_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             bus_err_q;
  logic             misalign_q;
  logic [31:0]      load_data_q;
  logic [31:0]      fault_addr_q;

  logic        start;
  logic        aligned;
  logic        timeout_hit;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (funct3_in[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_in[0];
      default: aligned = (addr_in[1:0] == 2'b00);
    endcase
  end

  assign start     = (state_q == S_IDLE) & valid_in & (mem_read_in | mem_write_in) & ~flush_in;
  assign stall_out = (state_q != S_IDLE) | (start & aligned);

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    if (mem_write_in) begin
      case (funct3_in[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << addr_in[1:0];
          wdata_d = {4{wdata_in[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << addr_in[1:0];
          wdata_d = {2{wdata_in[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = wdata_in;
        end
      endcase
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = dmem.dmem_resp_rdata[7:0];
      2'd1:    byte_sel = dmem.dmem_resp_rdata[15:8];
      2'd2:    byte_sel = dmem.dmem_resp_rdata[23:16];
      default: byte_sel = dmem.dmem_resp_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? dmem.dmem_resp_rdata[31:16] : dmem.dmem_resp_rdata[15:0];
    load_data_d = 32'h0;
    if (!we_q) begin
      // funct3[2] set means unsigned, so it suppresses sign replication
      case (funct3_q[1:0])
        2'b00:   load_data_d = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
        2'b01:   load_data_d = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
        default: load_data_d = dmem.dmem_resp_rdata;
      endcase
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      req_valid_q  <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      funct3_q     <= 3'b000;
      wstrb_q      <= 4'b0000;
      wdata_q      <= 32'h0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      bus_err_q    <= 1'b0;
      misalign_q   <= 1'b0;
      load_data_q  <= 32'h0;
      fault_addr_q <= 32'h0;
    end else begin
      done_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && aligned) begin
            addr_q      <= addr_in;
            we_q        <= mem_write_in;
            funct3_q    <= funct3_in;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end else if (start) begin
            misalign_q   <= 1'b1;
            fault_addr_q <= addr_in;
          end
        end
        S_REQ: begin
          if (dmem.dmem_req_ready) begin
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (dmem.dmem_resp_valid && !dmem.dmem_resp_err) begin
            done_q      <= 1'b1;
            load_data_q <= load_data_d;
            state_q     <= S_IDLE;
          end else if (dmem.dmem_resp_valid || timeout_hit) begin
            bus_err_q    <= 1'b1;
            fault_addr_q <= addr_q;
            state_q      <= S_IDLE;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req_valid = req_valid_q;
  assign dmem.dmem_req_we    = we_q;
  assign dmem.dmem_req_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_req_wdata = wdata_q;
  assign dmem.dmem_req_wstrb = wstrb_q;
  assign load_data_out       = load_data_q;
  assign done_out            = done_q;
  assign misalign_out        = misalign_q;
  assign bus_err_out         = bus_err_q;
  assign fault_addr_out      = fault_addr_q;

endmodule

`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit; consumes the EX/MEM register outputs and drives the data-memory bus.
- Issues one request per load/store, waits for the response, then returns aligned and extended load data toward MEM/WB.
- Asserts stall_out while a transaction is in flight so IF..EX/MEM hold.
- Flags misaligned accesses, bus errors and response timeouts to the trap logic.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in RESP state before bus_err_out; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  EX/MEM entry valid
mem_read_in  in  1  load
mem_write_in  in  1  store
funct3_in  in  3  access size/signedness (RV32I encoding)
addr_in  in  32  effective address (EX/MEM alu_result)
wdata_in  in  32  store data (EX/MEM mem_write_data)
flush_in  in  1  squash current EX/MEM entry
dmem_req_valid  out  1  bus request valid
dmem_req_ready  in  1  bus accepts request
dmem_req_we  out  1  1 = write
dmem_req_addr  out  32  word address, bits [1:0] = 0
dmem_req_wdata  out  32  lane-replicated store data
dmem_req_wstrb  out  4  byte enables; 0000 for reads
dmem_resp_valid  in  1  response/ack valid
dmem_resp_err  in  1  response carries error (sampled with resp_valid)
dmem_resp_rdata  in  32  read word
load_data_out  out  32  extracted load result, valid when done_out=1
done_out  out  1  one-cycle pulse: access completed OK
stall_out  out  1  pipeline hold request
misalign_out  out  1  one-cycle pulse: misaligned access rejected
bus_err_out  out  1  one-cycle pulse: resp_err or timeout
fault_addr_out  out  32  byte address of the faulting access

Behaviour:
- States: IDLE, REQ, RESP.
- Reset (async, any state): state=IDLE; all outputs 0; timeout counter 0. The bus is reset together with this block, so no abort handshake is needed.
- start = IDLE & valid_in & (mem_read_in | mem_write_in) & ~flush_in.
- Alignment: size byte (funct3[1:0]=00) always aligned; half (01) needs addr[0]=0; word (10) needs addr[1:0]=00; funct3[1:0]=11 is treated as word.
- stall_out = (state != IDLE) | (start & aligned). Combinational, so EX/MEM holds on the start cycle and stays held through completion.
- IDLE, start & aligned:
  - Register dmem_req_addr = {addr[31:2],2'b00}, we = mem_write_in, the byte offset, funct3 and wstrb/wdata.
  - Go to REQ; dmem_req_valid=1 from the next cycle.
- IDLE, start & misaligned:
  - No bus request.
  - Next cycle: misalign_out=1 for 1 cycle, fault_addr_out=addr_in.
  - No stall.
- wstrb: SB = 0001 << off; SH = 0011 << off; SW = 1111.
- wdata: SB replicates the byte 4x; SH replicates the half 2x; SW passes through.
- REQ: hold every dmem_req_* stable while ready=0. On valid & ready, drop req_valid next cycle, clear the counter and go to RESP.
- RESP: dmem_resp_valid acks both reads and writes.
  - resp_valid & ~err: next cycle done_out=1, load_data_out = extracted data, state=IDLE.
  - resp_valid & err: next cycle bus_err_out=1, fault_addr_out = latched byte address, no done, state=IDLE.
  - A response in the same cycle the request is accepted is illegal bus behaviour and is ignored.
- Timeout: when TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with no response, same as the err case. The counter saturates and never wraps.
- Load extraction:
  - LB/LBU: byte at off, sign-/zero-extend.
  - LH/LHU: half at off[1], sign-/zero-extend.
  - LW: whole word.
  - Stores: load_data_out=0.
- stall_out drops in the cycle done/bus_err/misalign pulses are registered (state already IDLE), so the pipeline advances exactly once per access.
- flush_in only qualifies start. It is ignored in REQ/RESP: issued transactions always complete.
- A start may be accepted in the same cycle done_out pulses (back-to-back; done_out is from the prior access).
- All pulses are exactly one cycle.

Test Plan:
- LW addr=0x100, ready=1 immediately, resp after 2 cycles with rdata=0xDEADBEEF -> req_addr=0x100, wstrb=0000; done_out with load_data_out=0xDEADBEEF; stall high 4 cycles, then low.
- LB addr=0x203 rdata=0x80FF_00_11 -> 0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x202 rdata=0x8001_1234 -> 0xFFFF8001. LHU -> 0x00008001.
- SB addr=0x301 wdata=0x000000AB -> req_addr=0x300, wstrb=0010, wdata=0xABABABAB. SH addr=0x302 wdata=0x1234 -> wstrb=1100, wdata=0x12341234. Ack -> done_out.
- LW addr=0x102 and SH addr=0x105 -> no dmem_req_valid; misalign_out pulse with fault_addr_out=0x102 / 0x105; stall_out never asserted.
- Backpressure: ready=0 for 5 cycles -> request fields stable throughout. Then resp_err=1 -> bus_err_out pulse, fault_addr_out = byte address, no done_out. With no response for 255 cycles (default) -> bus_err_out.
- Edge cases:
  - flush_in with valid load in IDLE -> no request.
  - reset_n low during RESP -> all outputs 0 immediately, IDLE after release.
  - Back-to-back LW then SW -> two distinct requests, two done pulses.
